// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon push-button input block.
package simon_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EMIT     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int NUM_BTN_DEFAULT         = 4;
    localparam int MAX_BTN                 = 8;

    // Only meaningful for a one-hot input; callers check one-hotness themselves.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_BTN-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < MAX_BTN; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/simon_debounce_bit.sv
// Two-flop synchroniser followed by a restart-on-bounce debounce counter for one button.
module simon_debounce_bit
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 20
)(
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            // The counter tops out at DEBOUNCE_CYCLES-1, so it can never wrap.
            if (r_sync2 != r_stable) begin
                if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_stable;

endmodule

// File: rtl/simon_button_in.sv
// Debounced Simon buttons to one press event per press on a valid/ready handshake.
// Build option SIMON_CHORD_FLAG_EN adds a one-cycle chord_err pulse output.
module simon_button_in
    import simon_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 20,
    parameter int IDX_W           = 2
)(
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               btn_valid,
    output logic [IDX_W-1:0]   btn_idx,
    input  logic               btn_ready
`ifdef SIMON_CHORD_FLAG_EN
    ,
    output logic               chord_err
`endif
);

    logic [NUM_BTN-1:0] w_level;
    logic [MAX_BTN-1:0] w_level_ext;
    logic               w_onehot;

    state_t             r_state;
    logic               r_valid;
    logic [IDX_W-1:0]   r_idx;
    logic               r_chord;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        simon_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .CLK  (CLK),
            .RST  (RST),
            .raw  (btn_raw[g]),
            .level(w_level[g])
        );
    end

    assign w_level_ext = MAX_BTN'(w_level);
    assign w_onehot    = (w_level != '0) &&
                         ((w_level & (w_level - NUM_BTN'(1))) == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_chord <= 1'b0;
        end else begin
            r_chord <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_onehot) begin
                        r_idx   <= IDX_W'(onehot_to_idx(w_level_ext));
                        r_valid <= 1'b1;
                        r_state <= EMIT;
                    end else if (w_level != '0) begin
                        r_chord <= 1'b1;
                        r_state <= WAIT_REL;
                    end
                end
                EMIT: begin
                    // Releasing the button here does not cancel the pending event.
                    if (btn_ready) begin
                        r_valid <= 1'b0;
                        r_state <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (w_level == '0) r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign btn_level = w_level;
    assign btn_valid = r_valid;
    assign btn_idx   = r_idx;

`ifdef SIMON_CHORD_FLAG_EN
    assign chord_err = r_chord;
`else
    logic w_chord_unused;
    assign w_chord_unused = r_chord;
`endif

endmodule
